des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator.
- Accepts one 64-bit key and emits the 16 48-bit round subkeys one per handshake. Order is K1..K16 for encryption or K16..K1 for decryption.
- Sits directly upstream of the DES round datapath, which consumes one subkey per round instead of building all 16 combinationally.
- Bit numbering follows FIPS 46-3: FIPS bit 1 = key[63], FIPS bit 64 = key[0].
  - Same convention applies to the 56-bit C||D register (bit 1 = MSB) and to sk_data (bit 1 = sk_data[47]).

Parameters:
- CHECK_PARITY, default 0: 1 = check odd parity per key byte at acceptance and drive parity_err; 0 = parity_err tied 0.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  synchronous active-low reset
- key_valid  input  1  key offer
- key_ready  output  1  block can accept a key
- key  input  64  DES key including parity bits
- decrypt  input  1  sampled with key: 0 = K1..K16, 1 = K16..K1
- sk_valid  output  1  subkey available
- sk_ready  input  1  consumer accepts subkey
- sk_data  output  48  current subkey, PC-2 of C||D
- sk_round  output  4  index of emitted subkey minus 1 (K1 = 0, K16 = 15)
- sk_last  output  1  high with the 16th emitted subkey of a key
- parity_err  output  1  registered at key acceptance; holds until the next acceptance

Behaviour:
- Reset (rst_n = 0 at a clk edge), from any state including mid-sequence:
  - state goes to IDLE; in-flight key discarded.
  - Outputs: key_ready = 1, sk_valid = 0, sk_last = 0, parity_err = 0, sk_round = 0, sk_data = 0.
  - C/D cleared to 0.
- Shift schedule s(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Counter n counts emitted subkeys, 0..15.
- IDLE: key_ready = 1, sk_valid = 0. On key_valid & key_ready:
  - {C,D} <= PC-1(key).
  - If decrypt = 0, each half is additionally rotated left by s(1) in the same cycle.
  - Latch the decrypt mode, n <= 0.
  - If CHECK_PARITY, parity_err <= 1 when any key byte has even parity.
  - Go to EMIT.
- EMIT: key_ready = 0, sk_valid = 1.
  - sk_data = PC-2({C,D}).
  - sk_round = decrypt ? 15-n : n.
  - sk_last = (n == 15).
  - All sk_* outputs hold stable while sk_ready = 0. Stall length is unbounded.
- On sk_valid & sk_ready in EMIT:
  - If n == 15: go to IDLE, sk_valid = 0 the next cycle.
  - Else n <= n+1, and each half rotates:
    - encrypt: left by s(n+2);
    - decrypt: right by s(16-n).
- Latency and throughput:
  - First subkey is valid the cycle after key acceptance.
  - With sk_ready held 1: one subkey per cycle, 16 consecutive cycles.
  - Earliest next key acceptance is the cycle after the last subkey is accepted. No overlap between keys.
- Decrypt start: C16 = C0, since the total shift is 28. The first decrypt subkey is PC-2(PC-1(key)) = K16.
- Rotations are within each 28-bit half only; there is no carry between C and D.
- key_valid while busy: ignored. key and decrypt are not sampled.
- sk_ready while IDLE: ignored.
- parity_err is informational only; the key is still accepted and scheduled.

Test Plan:
- Encrypt order: reset, then key = 0x133457799BBCDFF1, decrypt = 0, sk_ready = 1.
  - First sk_data = 0x1B02EFFC7072 (sk_round 0).
  - Second = 0x79AED9DBC9E5.
  - 16th = 0xCB3D8B0E17F5 with sk_last = 1 and sk_round 15.
  - parity_err = 0.
- Decrypt order: same key, decrypt = 1.
  - First sk_data = 0xCB3D8B0E17F5 (sk_round 15).
  - 15th = 0x79AED9DBC9E5.
  - 16th = 0x1B02EFFC7072 with sk_last = 1.
  - Full sequence is the exact reverse of the encrypt run.
- Backpressure: encrypt run with sk_ready random at 50%.
  - sk_data, sk_round and sk_last never change while sk_valid & !sk_ready.
  - Exactly 16 handshakes occur.
  - key_ready = 0 until the cycle after the last handshake.
- Busy rejection: assert key_valid with key = 0 during round 5.
  - Sequence is unaffected.
  - The new key is accepted only after IDLE is re-entered.
- Reset mid-operation: rst_n = 0 for 1 cycle after 7 subkeys.
  - Next cycle: sk_valid = 0, key_ready = 1.
  - A new encrypt of 0x133457799BBCDFF1 restarts at 0x1B02EFFC7072.
- Parity (CHECK_PARITY = 1):
  - key = 0x0000000000000000 → parity_err = 1 from the cycle after acceptance; 16 subkeys still emitted.
  - Then key = 0x133457799BBCDFF1 → parity_err = 0.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: accepts one 64-bit key and hands out the 16 round
// subkeys one per valid/ready handshake, in encrypt (K1..K16) or decrypt
// (K16..K1) order. FIPS 46-3 bit numbering: FIPS bit 1 is the MSB.
module des_key_schedule #(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk_data,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        parity_err
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    // PC-1: entry j (j = 1 at the MSB end) is the FIPS key bit that lands at C||D position j.
    localparam logic [447:0] PC1_TAB = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    // PC-2: entry j is the C||D position that lands at subkey position j.
    localparam logic [383:0] PC2_TAB = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  n_q, n_d;
    logic        dec_q, dec_d;
    logic        par_q, par_d;

    logic [55:0] pc1_out;
    logic [55:0] cd_cur;
    logic [47:0] pc2_out;
    logic [7:0]  byte_even;
    logic        key_par_bad;
    logic [4:0]  shift_idx;
    logic        shift_two;

    assign cd_cur = {c_q, d_q};

    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            localparam int SRC = 64 - int'(PC1_TAB[(55 - gi) * 8 +: 8]);
            assign pc1_out[55 - gi] = key[SRC];
        end
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            localparam int SRC = 56 - int'(PC2_TAB[(47 - gi) * 8 +: 8]);
            assign pc2_out[47 - gi] = cd_cur[SRC];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_par
            // A DES key byte is valid when it has odd parity.
            assign byte_even[gi] = ~^key[gi * 8 +: 8];
        end
    endgenerate

    assign key_par_bad = |byte_even;

    // Schedule entry for the next rotation: encrypt walks s(2)..s(16), decrypt s(16)..s(2).
    assign shift_idx = dec_q ? (5'd16 - {1'b0, n_q}) : ({1'b0, n_q} + 5'd2);
    assign shift_two = !((shift_idx == 5'd1) || (shift_idx == 5'd2) ||
                         (shift_idx == 5'd9) || (shift_idx == 5'd16));

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Next-state logic: key load in IDLE, per-handshake half rotation in EMIT.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        n_d     = n_q;
        dec_d   = dec_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    // Decrypt starts from C0/D0 directly since C16 = C0.
                    c_d     = decrypt ? pc1_out[55:28] : rot_l(pc1_out[55:28], 1'b0);
                    d_d     = decrypt ? pc1_out[27:0]  : rot_l(pc1_out[27:0], 1'b0);
                    dec_d   = decrypt;
                    n_d     = 4'd0;
                    par_d   = CHECK_PARITY ? key_par_bad : 1'b0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (sk_ready) begin
                    if (n_q == 4'd15) begin
                        state_d = S_IDLE;
                    end else begin
                        n_d = n_q + 4'd1;
                        c_d = dec_q ? rot_r(c_q, shift_two) : rot_l(c_q, shift_two);
                        d_d = dec_q ? rot_r(d_q, shift_two) : rot_l(d_q, shift_two);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            n_q     <= 4'd0;
            dec_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            n_q     <= n_d;
            dec_q   <= dec_d;
            par_q   <= par_d;
        end
    end

    assign key_ready  = (state_q == S_IDLE);
    assign sk_valid   = (state_q == S_EMIT);
    assign sk_data    = pc2_out;
    assign sk_round   = dec_q ? (4'd15 - n_q) : n_q;
    assign sk_last    = (state_q == S_EMIT) && (n_q == 4'd15);
    assign parity_err = par_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: spec vectors from a table, hand-written
// backpressure / busy / reset sequences, and random keys checked against
// a bit-level FIPS reference model using cumulative shift totals.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        parity_err;

    always #5 clk = ~clk;

    des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .decrypt    (decrypt),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .sk_data    (sk_data),
        .sk_round   (sk_round),
        .sk_last    (sk_last),
        .parity_err (parity_err)
    );

    int pc1_t[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                      10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                      23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48,
                      44,49,39,56,34,53, 46,42,50,36,29,32};
    int sched[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    int n_chk  = 0;
    int n_fail = 0;

    logic [47:0] obs_data[16];
    logic [3:0]  obs_round[16];
    logic        obs_last[16];
    logic [47:0] enc_data[16];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    // Reference subkey K_r: C_r/D_r are C0/D0 rotated left by the total shift.
    function automatic logic [47:0] ref_k(input logic [63:0] k, input int r);
        int tot;
        logic kb[65];
        logic c0[29];
        logic d0[29];
        logic cd[57];
        logic [47:0] res;
        tot = 0;
        for (int i = 0; i < r; i++) tot += sched[i];
        for (int i = 1; i <= 64; i++) kb[i] = k[64 - i];
        for (int i = 1; i <= 28; i++) begin
            c0[i] = kb[pc1_t[i - 1]];
            d0[i] = kb[pc1_t[i + 27]];
        end
        for (int i = 1; i <= 28; i++) begin
            cd[i]      = c0[((i - 1 + tot) % 28) + 1];
            cd[i + 28] = d0[((i - 1 + tot) % 28) + 1];
        end
        for (int j = 1; j <= 48; j++) res[48 - j] = cd[pc2_t[j - 1]];
        return res;
    endfunction

    function automatic logic ref_par(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            logic [7:0] by;
            by = k[b * 8 +: 8];
            if (^by == 1'b0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Offer a key for exactly one accepting edge, then scramble key/decrypt.
    task automatic accept(input logic [63:0] k, input logic dec);
        int w;
        w = 0;
        while (!key_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("key_ready_before_accept", 64'(key_ready), 64'd1);
        key_valid = 1'b1;
        key       = k;
        decrypt   = dec;
        @(negedge clk);
        key_valid = 1'b0;
        key       = {$urandom, $urandom};
        decrypt   = 1'($urandom_range(1));
    endtask

    // Consume up to stop_after subkeys, checking every cycle against the model.
    task automatic drain(input logic [63:0] k, input logic dec, input bit rnd,
                         input int inj_h, input int stop_after);
        int h, cyc, idx;
        bit hs, stalled;
        logic [47:0] pd;
        logic [3:0]  pr;
        logic        pl;
        h = 0; cyc = 0; stalled = 1'b0;
        pd = '0; pr = '0; pl = 1'b0;
        while (h < stop_after && cyc < 1000) begin
            idx = dec ? 16 - h : h + 1;
            chk("sk_valid_busy", 64'(sk_valid), 64'd1);
            chk("key_ready_busy", 64'(key_ready), 64'd0);
            chk("sk_data", 64'(sk_data), 64'(ref_k(k, idx)));
            chk("sk_round", 64'(sk_round), 64'(idx - 1));
            chk("sk_last", 64'(sk_last), 64'(h == 15));
            chk("parity_err", 64'(parity_err), 64'(ref_par(k)));
            if (stalled) begin
                chk("hold_data", 64'(sk_data), 64'(pd));
                chk("hold_round", 64'(sk_round), 64'(pr));
                chk("hold_last", 64'(sk_last), 64'(pl));
            end
            pd = sk_data; pr = sk_round; pl = sk_last;
            if (h == inj_h) begin
                key_valid = 1'b1;
                key       = 64'd0;
                decrypt   = 1'b0;
            end
            sk_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            hs       = sk_valid && sk_ready;
            stalled  = sk_valid && !sk_ready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                obs_data[h]  = pd;
                obs_round[h] = pr;
                obs_last[h]  = pl;
                $display("key=%h dec=%0d hs=%0d round=%0d data=%h last=%0d",
                         k, dec, h, pr, pd, pl);
                h++;
            end
        end
        if (h < stop_after) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout actual=%0d required=%0d", h, stop_after);
        end
        if (stop_after == 16) begin
            chk("sk_valid_after_last", 64'(sk_valid), 64'd0);
            chk("key_ready_after_last", 64'(key_ready), 64'd1);
        end
    endtask

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          h;
        logic [47:0] data;
        logic [3:0]  rnd;
        logic        last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key = '0; decrypt = 1'b0; sk_ready = 1'b0;
        tbl[0] = '{KEY_A, 1'b0, 0,  48'h1B02EFFC7072, 4'd0,  1'b0};
        tbl[1] = '{KEY_A, 1'b0, 1,  48'h79AED9DBC9E5, 4'd1,  1'b0};
        tbl[2] = '{KEY_A, 1'b0, 15, 48'hCB3D8B0E17F5, 4'd15, 1'b1};
        tbl[3] = '{KEY_A, 1'b1, 0,  48'hCB3D8B0E17F5, 4'd15, 1'b0};
        tbl[4] = '{KEY_A, 1'b1, 14, 48'h79AED9DBC9E5, 4'd1,  1'b0};
        tbl[5] = '{KEY_A, 1'b1, 15, 48'h1B02EFFC7072, 4'd0,  1'b1};

        repeat (2) @(negedge clk);
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_sk_valid", 64'(sk_valid), 64'd0);
        chk("rst_sk_last", 64'(sk_last), 64'd0);
        chk("rst_parity_err", 64'(parity_err), 64'd0);
        chk("rst_sk_round", 64'(sk_round), 64'd0);
        chk("rst_sk_data", 64'(sk_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Spec vectors: run each (key, mode) once, then compare the listed positions.
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || tbl[i].dec != tbl[i - 1].dec || tbl[i].key != tbl[i - 1].key) begin
                accept(tbl[i].key, tbl[i].dec);
                drain(tbl[i].key, tbl[i].dec, 1'b0, -1, 16);
                if (!tbl[i].dec) enc_data = obs_data;
            end
            chk("tbl_data", 64'(obs_data[tbl[i].h]), 64'(tbl[i].data));
            chk("tbl_round", 64'(obs_round[tbl[i].h]), 64'(tbl[i].rnd));
            chk("tbl_last", 64'(obs_last[tbl[i].h]), 64'(tbl[i].last));
        end
        for (int i = 0; i < 16; i++)
            chk("decrypt_reverse", 64'(obs_data[i]), 64'(enc_data[15 - i]));

        // Backpressure at 50%.
        accept(KEY_A, 1'b0);
        drain(KEY_A, 1'b0, 1'b1, -1, 16);

        // Busy rejection: key 0 offered from round 5 on, taken only once IDLE.
        accept(KEY_A, 1'b0);
        drain(KEY_A, 1'b0, 1'b0, 5, 16);
        @(negedge clk);
        key_valid = 1'b0;
        drain(64'd0, 1'b0, 1'b0, -1, 16);

        // Good-parity key after a bad one clears parity_err.
        accept(KEY_A, 1'b0);
        drain(KEY_A, 1'b0, 1'b0, -1, 16);

        // Reset after 7 subkeys.
        accept(KEY_A, 1'b0);
        drain(KEY_A, 1'b0, 1'b0, -1, 7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sk_valid", 64'(sk_valid), 64'd0);
        chk("midrst_key_ready", 64'(key_ready), 64'd1);
        chk("midrst_sk_last", 64'(sk_last), 64'd0);
        chk("midrst_sk_data", 64'(sk_data), 64'd0);
        accept(KEY_A, 1'b0);
        drain(KEY_A, 1'b0, 1'b0, -1, 16);
        chk("restart_first", 64'(obs_data[0]), 64'h1B02EFFC7072);

        // Random keys, modes and backpressure.
        for (int t = 0; t < 10; t++) begin
            logic [63:0] rk;
            logic rd;
            rk = {$urandom, $urandom};
            rd = 1'($urandom_range(1));
            accept(rk, rd);
            drain(rk, rd, 1'b1, -1, 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
